// File: rtl/conv_pkg.sv
// Shared definitions for the 5x5 streaming convolution engine.
// Holds image/filter geometry, datapath widths, FSM state encodings and the
// coefficient-unpack helper used by the MAC tree.
package conv_pkg;

    localparam int unsigned IMG_W  = 50;
    localparam int unsigned IMG_H  = 50;
    localparam int unsigned K      = 5;
    localparam int unsigned PIX_W  = 12;
    localparam int unsigned COEF_W = 8;
    localparam int unsigned ADDR_W = 17;
    localparam int unsigned OUT_W  = 20;

    localparam int unsigned NTAP       = K * K;
    localparam int unsigned WIN_W      = NTAP * PIX_W;
    localparam int unsigned COEF_VEC_W = NTAP * COEF_W;
    localparam int unsigned PROD_W     = PIX_W + COEF_W + 1;

    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned COL_W = $clog2(IMG_W + 2);
    localparam int unsigned FI_W  = $clog2(K);

    // FSM state encodings
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PRELOAD = 2'd1;
    localparam logic [1:0] S_COLUMN  = 2'd2;
    localparam logic [1:0] S_WRITE   = 2'd3;

    // Signed coefficient for tap k = K*i + j out of the packed coefficient vector
    function automatic logic signed [COEF_W-1:0] coef_at(
        input logic [COEF_VEC_W-1:0] f,
        input int unsigned           k
    );
        return $signed(f[k*COEF_W +: COEF_W]);
    endfunction

endpackage

// File: rtl/conv_mac_5x5.sv
// Combinational 25-tap multiply-accumulate for the 5x5 window.
// Ports:
//   win   - window pixels, tap k = 5*i+j at win[12k +: 12], unsigned
//   coef  - packed signed coefficients, tap k at coef[8k +: 8]
//   mac_c - sum of products, wrapped to OUT_W bits (combinational)
module conv_mac_5x5
    import conv_pkg::*;
(
    input  logic [WIN_W-1:0]      win,
    input  logic [COEF_VEC_W-1:0] coef,
    output logic [OUT_W-1:0]      mac_c
);

    logic signed [PROD_W-1:0] prod;
    logic        [OUT_W-1:0]  acc;

    // Accumulating modulo 2^OUT_W gives the same low bits as a full-width sum
    always_comb begin
        prod = '0;
        acc  = '0;
        for (int unsigned k = 0; k < NTAP; k++) begin
            prod = PROD_W'($signed({1'b0, win[k*PIX_W +: PIX_W]}))
                 * PROD_W'(coef_at(coef, k));
            acc  = acc + OUT_W'(prod);
        end
        mac_c = acc;
    end

endmodule

// File: rtl/conv2d_5x5.sv
// Streaming 5x5 "same" convolution over a 50x50 image in word memory.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - one-cycle frame start, accepted only while ready=1
//   f_coeff      - packed signed coefficients, latched on accepted start
//   d_in         - pixel at ReadAddress, valid in the same cycle
//   ReadAddress  - pixel fetch address, row-major
//   WriteAddress - output address, row-major
//   d_out        - signed output pixel
//   ready        - idle indicator
//   WriteEnable  - one-cycle output write strobe
module conv2d_5x5
    import conv_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [COEF_VEC_W-1:0] f_coeff,
    input  logic [PIX_W-1:0]      d_in,
    output logic [ADDR_W-1:0]     ReadAddress,
    output logic [ADDR_W-1:0]     WriteAddress,
    output logic [OUT_W-1:0]      d_out,
    output logic                  ready,
    output logic                  WriteEnable
);

    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] LAST_FCOL = COL_W'(IMG_W + 1);
    localparam logic [FI_W-1:0]  LAST_FI   = FI_W'(K - 1);

    logic [1:0]              state_q,   state_d;
    logic [ROW_W-1:0]        row_q,     row_d;
    logic [COL_W-1:0]        fcol_q,    fcol_d;     // column being fetched
    logic [FI_W-1:0]         fi_q,      fi_d;       // tap row within the column
    logic [ADDR_W-1:0]       wcount_q,  wcount_d;
    logic [COEF_VEC_W-1:0]   coef_q,    coef_d;
    logic [WIN_W-1:0]        win_q,     win_d;
    logic [(K-1)*PIX_W-1:0]  colbuf_q,  colbuf_d;
    logic                    pending_q, pending_d;  // window holds a finished output
    logic [ADDR_W-1:0]       raddr_q,   raddr_d;
    logic [ADDR_W-1:0]       waddr_q,   waddr_d;
    logic [OUT_W-1:0]        dout_q,    dout_d;
    logic                    we_q,      we_d;
    logic                    ready_q,   ready_d;

    logic [PIX_W-1:0]        pix;
    logic [K*PIX_W-1:0]      newcol;
    logic [OUT_W-1:0]        mac_c;

    // Fetch of tap row fi in column fcol for output row `row` lies inside the image
    function automatic logic fetch_valid(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] fcol,
        input logic [FI_W-1:0]  fi
    );
        int pr;
        pr = int'(row) + int'(fi) - 2;
        return (pr >= 0) && (pr < int'(IMG_H)) && (int'(fcol) < int'(IMG_W));
    endfunction

    function automatic logic [ADDR_W-1:0] fetch_addr(
        input logic [ROW_W-1:0] row,
        input logic [COL_W-1:0] fcol,
        input logic [FI_W-1:0]  fi
    );
        int pr;
        pr = int'(row) + int'(fi) - 2;
        return ADDR_W'(pr * int'(IMG_W) + int'(fcol));
    endfunction

    conv_mac_5x5 u_mac (
        .win   (win_q),
        .coef  (coef_q),
        .mac_c (mac_c)
    );

    // Next-state, datapath and output logic
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        fcol_d    = fcol_q;
        fi_d      = fi_q;
        wcount_d  = wcount_q;
        coef_d    = coef_q;
        win_d     = win_q;
        colbuf_d  = colbuf_q;
        pending_d = 1'b0;
        raddr_d   = raddr_q;
        waddr_d   = waddr_q;
        dout_d    = dout_q;
        we_d      = 1'b0;

        pix    = fetch_valid(row_q, fcol_q, fi_q) ? d_in : '0;
        newcol = {pix, colbuf_q};

        // Completed window from the previous shift is written out now,
        // overlapping the next column fetch
        if (pending_q) begin
            we_d     = 1'b1;
            dout_d   = mac_c;
            waddr_d  = wcount_q;
            wcount_d = wcount_q + ADDR_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    coef_d   = f_coeff;
                    row_d    = '0;
                    fcol_d   = '0;
                    fi_d     = '0;
                    wcount_d = '0;
                    state_d  = S_PRELOAD;
                end
            end

            S_PRELOAD, S_COLUMN: begin
                if (fi_q != LAST_FI) begin
                    colbuf_d[fi_q*PIX_W +: PIX_W] = pix;
                    fi_d = fi_q + FI_W'(1);
                end else begin
                    fi_d = '0;
                    // Shift left by one column; column 0 of a row also clears
                    // the stale window from the previous row
                    for (int unsigned i = 0; i < K; i++) begin
                        for (int unsigned j = 0; j < K - 1; j++) begin
                            win_d[(i*K+j)*PIX_W +: PIX_W] = (fcol_q == '0) ? '0
                                : win_q[(i*K+j+1)*PIX_W +: PIX_W];
                        end
                        win_d[(i*K+K-1)*PIX_W +: PIX_W] = newcol[i*PIX_W +: PIX_W];
                    end
                    if (fcol_q >= COL_W'(2)) begin
                        pending_d = 1'b1;
                    end
                    if (fcol_q == LAST_FCOL) begin
                        fcol_d = '0;
                        if (row_q == LAST_ROW) begin
                            state_d = S_WRITE;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = S_PRELOAD;
                        end
                    end else begin
                        fcol_d  = fcol_q + COL_W'(1);
                        state_d = (fcol_q == '0) ? S_PRELOAD : S_COLUMN;
                    end
                end
            end

            // Drains the last output, then returns to idle
            S_WRITE: begin
                if (!pending_q) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        // Address is set up one cycle ahead; out-of-image fetches hold it
        if ((state_d == S_PRELOAD || state_d == S_COLUMN)
            && fetch_valid(row_d, fcol_d, fi_d)) begin
            raddr_d = fetch_addr(row_d, fcol_d, fi_d);
        end

        ready_d = (state_d == S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            row_q     <= '0;
            fcol_q    <= '0;
            fi_q      <= '0;
            wcount_q  <= '0;
            coef_q    <= '0;
            win_q     <= '0;
            colbuf_q  <= '0;
            pending_q <= 1'b0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            dout_q    <= '0;
            we_q      <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            fcol_q    <= fcol_d;
            fi_q      <= fi_d;
            wcount_q  <= wcount_d;
            coef_q    <= coef_d;
            win_q     <= win_d;
            colbuf_q  <= colbuf_d;
            pending_q <= pending_d;
            raddr_q   <= raddr_d;
            waddr_q   <= waddr_d;
            dout_q    <= dout_d;
            we_q      <= we_d;
            ready_q   <= ready_d;
        end
    end

    assign ReadAddress  = raddr_q;
    assign WriteAddress = waddr_q;
    assign d_out        = dout_q;
    assign WriteEnable  = we_q;
    assign ready        = ready_q;

endmodule

// File: tb/tb_conv2d_5x5.sv
// Directed testbench for conv2d_5x5: impulse, padding, signed centre tap,
// handshake, mid-frame reset and coefficient latching.
module tb_conv2d_5x5;

    logic          clk;
    logic          rst;
    logic          start;
    logic [199:0]  f_coeff;
    logic [11:0]   d_in;
    logic [16:0]   ReadAddress;
    logic [16:0]   WriteAddress;
    logic [19:0]   d_out;
    logic          ready;
    logic          WriteEnable;

    logic [11:0]   img     [0:2499];
    logic [19:0]   out_mem [0:2499];
    logic [199:0]  latched;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_addr = 0;
    int wr_count = 0;
    int order_err = 0;
    int consec_err = 0;
    logic prev_we = 1'b0;

    logic [199:0] coef_imp;
    logic [199:0] coef_ones;
    logic [199:0] coef_ctr;

    conv2d_5x5 dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .f_coeff      (f_coeff),
        .d_in         (d_in),
        .ReadAddress  (ReadAddress),
        .WriteAddress (WriteAddress),
        .d_out        (d_out),
        .ready        (ready),
        .WriteEnable  (WriteEnable)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign d_in = (ReadAddress < 17'd2500) ? img[ReadAddress[11:0]] : 12'd0;

    // Output capture and write-order monitor
    always @(negedge clk) begin
        if (WriteEnable) begin
            if (int'(WriteAddress) != exp_addr) order_err++;
            if (WriteAddress < 17'd2500) out_mem[WriteAddress[11:0]] = d_out;
            if (prev_we) consec_err++;
            exp_addr++;
            wr_count++;
        end
        prev_we = WriteEnable;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic int ix(input int r, input int c);
        return r * 50 + c;
    endfunction

    // Direct correlation sum over the stored image with the latched coefficients
    function automatic logic [19:0] model(input int r, input int c);
        int acc;
        int w;
        int rr;
        int cc;
        logic [7:0] b;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                rr = r + i - 2;
                cc = c + j - 2;
                b  = latched[8*(5*i+j) +: 8];
                w  = int'($signed(b));
                if (rr >= 0 && rr < 50 && cc >= 0 && cc < 50)
                    acc += w * int'(img[ix(rr, cc)]);
            end
        end
        return acc[19:0];
    endfunction

    task automatic fill_img(input logic [11:0] v);
        for (int a = 0; a < 2500; a++) img[a] = v;
    endtask

    task automatic run_frame(input logic [199:0] c_start, input logic [199:0] c_later,
                             input bit extra_start);
        int cyc;
        int mism;
        exp_addr = 0; wr_count = 0; order_err = 0; consec_err = 0;
        for (int a = 0; a < 2500; a++) out_mem[a] = 20'h0;
        f_coeff = c_start;
        latched = c_start;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        f_coeff = c_later;
        check("ready_drop", 32'(ready), 32'd0);
        cyc = 1;
        while (ready !== 1'b1 && cyc < 13200) begin
            @(negedge clk);
            cyc++;
            start = (extra_start && (cyc == 300 || cyc == 7000)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        check("frame_done", 32'(ready), 32'd1);
        check("frame_time", 32'(cyc <= 13100), 32'd1);
        check("wr_count", 32'(wr_count), 32'd2500);
        check("wr_order", 32'(order_err), 32'd0);
        check("we_gap", 32'(consec_err), 32'd0);
        mism = 0;
        for (int r = 0; r < 50; r++)
            for (int c = 0; c < 50; c++)
                if (out_mem[ix(r, c)] !== model(r, c)) mism++;
        check("frame_model", 32'(mism), 32'd0);
    endtask

    task automatic check_pad_spots();
        check("pad_0_0",   32'(out_mem[ix(0, 0)]),   32'd9);
        check("pad_0_25",  32'(out_mem[ix(0, 25)]),  32'd15);
        check("pad_25_25", 32'(out_mem[ix(25, 25)]), 32'd25);
        check("pad_49_49", 32'(out_mem[ix(49, 49)]), 32'd9);
    endtask

    initial begin
        int cyc;
        coef_imp  = 200'h050000000400fffeff00000000000000010201000200000001;
        coef_ones = {25{8'h01}};
        coef_ctr  = '0;
        coef_ctr[12*8 +: 8] = 8'h80;

        rst = 1'b1; start = 1'b0; f_coeff = '0; latched = '0;
        fill_img(12'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_we",    32'(WriteEnable), 32'd0);
        check("rst_raddr", 32'(ReadAddress), 32'd0);
        check("rst_waddr", 32'(WriteAddress), 32'd0);
        check("rst_dout",  32'(d_out), 32'd0);

        // Impulse, with stray start pulses mid-frame
        img[ix(25, 25)] = 12'd1;
        run_frame(coef_imp, coef_imp, 1'b1);
        check("imp_27_27", 32'(out_mem[ix(27, 27)]), 32'h00001);
        check("imp_23_23", 32'(out_mem[ix(23, 23)]), 32'h00005);
        check("imp_25_25", 32'(out_mem[ix(25, 25)]), 32'h00000);
        check("imp_27_23", 32'(out_mem[ix(27, 23)]), 32'h00002);
        check("imp_23_27", 32'(out_mem[ix(23, 27)]), 32'h00004);
        check("imp_24_25", 32'(out_mem[ix(24, 25)]), 32'hFFFFE);
        check("imp_24_24", 32'(out_mem[ix(24, 24)]), 32'hFFFFF);
        check("imp_26_25", 32'(out_mem[ix(26, 25)]), 32'h00002);
        check("imp_22_22", 32'(out_mem[ix(22, 22)]), 32'h00000);

        // Zero padding at edges and corners
        fill_img(12'd1);
        run_frame(coef_ones, coef_ones, 1'b0);
        check_pad_spots();
        check("pad_1_1",  32'(out_mem[ix(1, 1)]),  32'd16);
        check("pad_0_1",  32'(out_mem[ix(0, 1)]),  32'd12);
        check("pad_49_0", 32'(out_mem[ix(49, 0)]), 32'd9);

        // Negative centre tap, including the full-scale pixel
        fill_img(12'd100);
        img[ix(10, 10)] = 12'd4095;
        run_frame(coef_ctr, coef_ctr, 1'b0);
        check("ctr_0_0",   32'(out_mem[ix(0, 0)]),   32'hFCE00);
        check("ctr_49_49", 32'(out_mem[ix(49, 49)]), 32'hFCE00);
        check("ctr_25_25", 32'(out_mem[ix(25, 25)]), 32'hFCE00);
        check("ctr_10_10", 32'(out_mem[ix(10, 10)]), 32'h80080);
        check("ctr_10_11", 32'(out_mem[ix(10, 11)]), 32'hFCE00);

        // Abort mid-frame with reset
        fill_img(12'd1);
        exp_addr = 0; wr_count = 0;
        f_coeff = coef_ctr;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (wr_count < 1000 && cyc < 8000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_1000", 32'(wr_count >= 1000), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_we",    32'(WriteEnable), 32'd0);
        check("abort_raddr", 32'(ReadAddress), 32'd0);
        check("abort_waddr", 32'(WriteAddress), 32'd0);
        check("abort_dout",  32'(d_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Restart after abort; coefficients change right after start
        run_frame(coef_ones, coef_ctr, 1'b0);
        check_pad_spots();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
